// File: rtl/decode_stage_pl.sv
// decode_stage_pl: IF/ID pipeline register plus instruction decode, register file, immediates,
// writeback bypass and load-use hazard detection.
module decode_stage_pl #(
  parameter int XLEN = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int BYPASS = 1,
  localparam int RA = $clog2(REG_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic [31:0]              instr_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     reg_write_w,
  input  logic [RA-1:0]            rd_w,
  input  logic [XLEN-1:0]          result_w,
  input  logic [4:0]               rd_e,
  input  logic                     mem_read_e,
  output logic                     valid_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic [4:0]               rs1_d,
  output logic [4:0]               rs2_d,
  output logic [4:0]               rd_d,
  output logic [2:0]               funct3_d,
  output logic [XLEN-1:0]          imm_d,
  output logic [XLEN-1:0]          rd1_d,
  output logic [XLEN-1:0]          rd2_d,
  output logic                     reg_write_d,
  output logic                     mem_write_d,
  output logic                     branch_d,
  output logic                     jump_d,
  output logic                     illegal_d,
  output logic                     load_use_hazard
);
  typedef enum logic [2:0] {IMM_N, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_t;
  localparam logic [5:0] LIM = 6'(REG_COUNT);
  logic                     r_valid;
  logic [31:0]              r_instr;
  logic [ADDRESS_WIDTH-1:0] r_pc, r_pc4;
  logic [XLEN-1:0]          r_rf [REG_COUNT];
  imm_t                     w_imm_t;
  logic w_reg_write, w_mem_write, w_branch, w_jump, w_known, w_rs1_used, w_rs2_used;
  logic w_oor, w_illegal, w_en, w_byp;
  always_ff @(posedge clk) begin
    if (!rst_n || flush_d) begin
      r_valid <= 1'b0;
      r_instr <= 32'h0000_0013;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (!stall_d) begin
      r_valid <= valid_f;
      r_instr <= instr_f;
      r_pc    <= pc_f;
      r_pc4   <= pc_plus4_f;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n)
      for (int k = 0; k < REG_COUNT; k++) r_rf[k] <= '0;
    else if (reg_write_w && rd_w != '0)
      r_rf[rd_w] <= result_w;
  end
  always_comb begin
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_known     = 1'b1;
    w_rs1_used  = 1'b1;
    w_rs2_used  = 1'b0;
    w_imm_t     = IMM_N;
    case (r_instr[6:0])
      7'b0110011: begin w_reg_write = 1'b1; w_rs2_used = 1'b1; end
      7'b0010011, 7'b0000011: begin w_reg_write = 1'b1; w_imm_t = IMM_I; end
      7'b1100111: begin w_reg_write = 1'b1; w_jump = 1'b1; w_imm_t = IMM_I; end
      7'b0100011: begin w_mem_write = 1'b1; w_rs2_used = 1'b1; w_imm_t = IMM_S; end
      7'b1100011: begin w_branch = 1'b1; w_rs2_used = 1'b1; w_imm_t = IMM_B; end
      7'b1101111: begin w_reg_write = 1'b1; w_jump = 1'b1; w_rs1_used = 1'b0; w_imm_t = IMM_J; end
      7'b0110111, 7'b0010111: begin w_reg_write = 1'b1; w_rs1_used = 1'b0; w_imm_t = IMM_U; end
      default: begin w_known = 1'b0; w_rs1_used = 1'b0; end
    endcase
  end
  assign valid_d    = r_valid;
  assign pc_d       = r_pc;
  assign pc_plus4_d = r_pc4;
  assign rs1_d      = r_instr[19:15];
  assign rs2_d      = r_instr[24:20];
  assign rd_d       = r_instr[11:7];
  assign funct3_d   = r_instr[14:12];
  assign imm_d = (w_imm_t == IMM_I) ? XLEN'($signed(r_instr[31:20])) :
                 (w_imm_t == IMM_S) ? XLEN'($signed({r_instr[31:25], r_instr[11:7]})) :
                 (w_imm_t == IMM_B) ? XLEN'($signed({r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0})) :
                 (w_imm_t == IMM_J) ? XLEN'($signed({r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0})) :
                 (w_imm_t == IMM_U) ? XLEN'($signed({r_instr[31:12], 12'b0})) : '0;
  // Only indices an instruction actually uses can make it illegal on a reduced register file.
  assign w_oor = (w_rs1_used && {1'b0, rs1_d} >= LIM) || (w_rs2_used && {1'b0, rs2_d} >= LIM) ||
                 (w_reg_write && {1'b0, rd_d} >= LIM);
  assign w_illegal   = r_valid && (!w_known || w_oor);
  assign w_en        = r_valid && !w_illegal;
  assign illegal_d   = w_illegal;
  assign reg_write_d = w_en && w_reg_write;
  assign mem_write_d = w_en && w_mem_write;
  assign branch_d    = w_en && w_branch;
  assign jump_d      = w_en && w_jump;
  assign w_byp = (BYPASS != 0) && reg_write_w && rd_w != '0;
  assign rd1_d = (w_byp && 5'(rd_w) == rs1_d) ? result_w : r_rf[rs1_d[RA-1:0]];
  assign rd2_d = (w_byp && 5'(rd_w) == rs2_d) ? result_w : r_rf[rs2_d[RA-1:0]];
  assign load_use_hazard = r_valid && mem_read_e && rd_e != 5'd0 &&
                           ((w_rs1_used && rd_e == rs1_d) || (w_rs2_used && rd_e == rs2_d));
endmodule

// File: tb/tb_decode_stage_pl.sv
// tb_decode_stage_pl: directed checks of three decode_stage_pl variants
// (default, BYPASS=0, REG_COUNT=16) driven from shared stimulus.
module tb_decode_stage_pl;
  localparam int BYP [3] = '{1, 0, 1};
  localparam int RC  [3] = '{32, 32, 16};
  logic        clk = 1'b0;
  logic        rst_n, valid_f, stall_d, flush_d, reg_write_w, mem_read_e;
  logic [31:0] pc_f, pc_plus4_f, instr_f, result_w;
  logic [4:0]  rd_w, rd_e;
  logic        valid_d [3], reg_write_d [3], mem_write_d [3], branch_d [3], jump_d [3];
  logic        illegal_d [3], hz [3];
  logic [31:0] pc_d [3], pc_plus4_d [3], imm_d [3], rd1_d [3], rd2_d [3];
  logic [4:0]  rs1_d [3], rs2_d [3], rd_d [3];
  logic [2:0]  funct3_d [3];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    decode_stage_pl #(.BYPASS(BYP[g]), .REG_COUNT(RC[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .valid_f(valid_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
      .instr_f(instr_f), .stall_d(stall_d), .flush_d(flush_d), .reg_write_w(reg_write_w),
      .rd_w(rd_w[$clog2(RC[g])-1:0]), .result_w(result_w), .rd_e(rd_e), .mem_read_e(mem_read_e),
      .valid_d(valid_d[g]), .pc_d(pc_d[g]), .pc_plus4_d(pc_plus4_d[g]), .rs1_d(rs1_d[g]),
      .rs2_d(rs2_d[g]), .rd_d(rd_d[g]), .funct3_d(funct3_d[g]), .imm_d(imm_d[g]),
      .rd1_d(rd1_d[g]), .rd2_d(rd2_d[g]), .reg_write_d(reg_write_d[g]),
      .mem_write_d(mem_write_d[g]), .branch_d(branch_d[g]), .jump_d(jump_d[g]),
      .illegal_d(illegal_d[g]), .load_use_hazard(hz[g]));
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] ins, input logic [31:0] pc);
    valid_f = 1'b1; instr_f = ins; pc_f = pc; pc_plus4_f = pc + 32'd4;
    tick();
  endtask
  task automatic en0(input string tag, input int g);
    check({tag, "_en"}, {28'd0, reg_write_d[g], mem_write_d[g], branch_d[g], jump_d[g]}, 32'd0);
  endtask
  initial begin
    rst_n = 1'b0; valid_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; reg_write_w = 1'b0;
    mem_read_e = 1'b0; pc_f = '0; pc_plus4_f = '0; instr_f = '0; result_w = '0; rd_w = '0; rd_e = '0;
    tick(); tick();
    check("rst_valid", 32'(valid_d[0]), 32'd0);
    check("rst_pc", pc_d[0], 32'd0);
    check("rst_imm", imm_d[0], 32'd0);
    check("rst_rd1", rd1_d[0], 32'd0);
    check("rst_flags", {30'd0, illegal_d[0], hz[0]}, 32'd0);
    en0("rst", 0);
    rst_n = 1'b1;
    load(32'h0050_0093, 32'h100);
    check("addi_valid", 32'(valid_d[0]), 32'd1);
    check("addi_rw", 32'(reg_write_d[0]), 32'd1);
    check("addi_rd", 32'(rd_d[0]), 32'd1);
    check("addi_imm", imm_d[0], 32'd5);
    check("addi_pc", pc_d[0], 32'h100);
    check("addi_pc4", pc_plus4_d[0], 32'h104);
    load(32'h0031_8233, 32'h104);
    reg_write_w = 1'b1; rd_w = 5'd3; result_w = 32'hDEAD_BEEF;
    #1;
    check("byp_rd1", rd1_d[0], 32'hDEAD_BEEF);
    check("byp_rd2", rd2_d[0], 32'hDEAD_BEEF);
    check("nobyp_rd1_before", rd1_d[1], 32'd0);
    tick();
    reg_write_w = 1'b0;
    #1;
    check("nobyp_rd1_after", rd1_d[1], 32'hDEAD_BEEF);
    check("rf_rd2_after", rd2_d[0], 32'hDEAD_BEEF);
    load(32'hFE20_AE23, 32'h108);
    check("sw_mw", 32'(mem_write_d[0]), 32'd1);
    check("sw_rw", 32'(reg_write_d[0]), 32'd0);
    check("sw_imm", imm_d[0], 32'hFFFF_FFFC);
    check("sw_f3", 32'(funct3_d[0]), 32'd2);
    load(32'hFF9F_F0EF, 32'h10C);
    check("jal_jump", 32'(jump_d[0]), 32'd1);
    check("jal_rw", 32'(reg_write_d[0]), 32'd1);
    check("jal_imm", imm_d[0], 32'hFFFF_FFF8);
    load(32'h0002_8333, 32'h110);
    mem_read_e = 1'b1; rd_e = 5'd5;
    #1;
    check("lu_hz", 32'(hz[0]), 32'd1);
    rd_e = 5'd0;
    #1;
    check("lu_rd0", 32'(hz[0]), 32'd0);
    rd_e = 5'd5;
    load(32'h0000_12B7, 32'h114);
    check("lu_lui", 32'(hz[0]), 32'd0);
    check("lui_imm", imm_d[0], 32'h0000_1000);
    mem_read_e = 1'b0; rd_e = 5'd0;
    load(32'h0050_0093, 32'h200);
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load(32'h0000_0063 | (i << 8), 32'h300 + 32'(i));
      check("stall_pc", pc_d[0], 32'h200);
      check("stall_imm", imm_d[0], 32'd5);
      check("stall_rw", 32'(reg_write_d[0]), 32'd1);
    end
    flush_d = 1'b1;
    tick();
    check("flush_valid", 32'(valid_d[0]), 32'd0);
    check("flush_pc", pc_d[0], 32'd0);
    check("flush_rd", 32'(rd_d[0]), 32'd0);
    en0("flush", 0);
    stall_d = 1'b0; flush_d = 1'b0;
    load(32'h0010_0A13, 32'h120);
    check("rc16_illegal", 32'(illegal_d[2]), 32'd1);
    en0("rc16", 2);
    check("rc32_legal", 32'(illegal_d[0]), 32'd0);
    check("rc32_rw", 32'(reg_write_d[0]), 32'd1);
    load(32'h0000_007F, 32'h124);
    check("op7f_illegal", 32'(illegal_d[0]), 32'd1);
    check("op7f_imm", imm_d[0], 32'd0);
    en0("op7f", 0);
    valid_f = 1'b0; instr_f = 32'h0050_0093;
    tick();
    check("inv_valid", 32'(valid_d[0]), 32'd0);
    en0("inv", 0);
    reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'h55;
    load(32'h0000_0233, 32'h128);
    check("x0_byp", rd1_d[0], 32'd0);
    tick();
    reg_write_w = 1'b0;
    #1;
    check("x0_rf", rd1_d[0], 32'd0);
    load(32'h0031_8233, 32'h12C);
    check("pre_rst_x3", rd1_d[0], 32'hDEAD_BEEF);
    stall_d = 1'b1; rst_n = 1'b0;
    tick();
    check("rst_stall_valid", 32'(valid_d[0]), 32'd0);
    check("rst_stall_rs1", 32'(rs1_d[0]), 32'd0);
    stall_d = 1'b0; rst_n = 1'b1;
    load(32'h0031_8233, 32'h130);
    check("rst_stall_x3", rd1_d[0], 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage_pl.md
Name: decode_stage_pl

Overview:
Parametrised decode stage with an integrated IF/ID pipeline register. It adds stall, flush, valid tracking, load-use hazard detection, writeback-to-decode bypass, and a configurable register count (RV32I = 32, RV32E = 16). The block sits between fetch and the ID/EX register. It holds the fetched instruction for one cycle, decodes it, reads the internal register file and generates the immediate.

Parameters:
- XLEN, 32, data/register width.
- ADDRESS_WIDTH, 32, PC width.
- REG_COUNT, 32, number of architectural registers (16 or 32). RA = $clog2(REG_COUNT).
- BYPASS, 1, enables write-through from the writeback port to the read ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- valid_f  in  1  fetch output is valid
- pc_f  in  ADDRESS_WIDTH  fetch PC
- pc_plus4_f  in  ADDRESS_WIDTH  fetch PC+4
- instr_f  in  32  fetched instruction
- stall_d  in  1  hold IF/ID contents
- flush_d  in  1  squash IF/ID contents
- reg_write_w  in  1  writeback enable
- rd_w  in  RA  writeback destination
- result_w  in  XLEN  writeback data
- rd_e  in  5  EX-stage destination
- mem_read_e  in  1  EX-stage instruction is a load
- valid_d  out  1  decode slot holds a live instruction
- pc_d, pc_plus4_d  out  ADDRESS_WIDTH  registered PC, PC+4
- rs1_d, rs2_d, rd_d  out  5  instr[19:15], instr[24:20], instr[11:7]
- funct3_d  out  3  instr[14:12]
- imm_d  out  XLEN  sign-extended immediate
- rd1_d, rd2_d  out  XLEN  register operands
- reg_write_d, mem_write_d, branch_d, jump_d  out  1  control enables
- illegal_d  out  1  unsupported opcode or out-of-range register index
- load_use_hazard  out  1  stall request to fetch/hazard logic

Behaviour:
- IF/ID register update priority on each clk edge: rst_n=0 > flush_d > stall_d > load.
  - Reset and flush: valid=0, instr=0x00000013 (NOP), pc=0, pc_plus4=0.
  - Stall: all fields hold.
  - Load: valid<=valid_f, instr/pc/pc_plus4 <= fetch inputs.
- Latency: an instruction loaded at edge N drives all decode outputs combinationally after edge N. Outputs are not registered again.
- Reset values of outputs follow from the NOP encoding with valid=0:
  - valid_d=0, pc_d=0, rs1_d=rs2_d=0, rd_d=0, funct3_d=0, imm_d=0.
  - All enables 0, illegal_d=0, load_use_hazard=0.
  - rd1_d=rd2_d=0.
- Opcode table (instr[6:0] -> enables, imm type):
  - 0110011: reg_write, no immediate (imm_d=0).
  - 0010011, 0000011: reg_write, I-type.
  - 1100111: reg_write + jump, I-type.
  - 0100011: mem_write, S-type.
  - 1100011: branch, B-type.
  - 1101111: reg_write + jump, J-type.
  - 0110111, 0010111: reg_write, U-type.
  - Any other opcode: illegal, imm_d=0.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - U = {instr[31:12], 12'b0}.
  - Sign extension is to XLEN.
- Register usage:
  - rs1 is used by all legal opcodes except 0110111, 0010111 and 1101111.
  - rs2 is used by 0110011, 0100011 and 1100011.
  - rd is used when reg_write.
- illegal_d = valid_d AND (unknown opcode OR any used index >= REG_COUNT). When illegal_d=1, all enables are forced to 0.
- When valid_d=0, all enables, illegal_d and load_use_hazard are 0.
- Register file:
  - REG_COUNT x XLEN registers; reset clears all to 0.
  - Write at the clk edge when reg_write_w=1 and rd_w!=0. x0 is never written and always reads 0.
  - Reads are combinational, indexed by the low RA bits of rs1_d/rs2_d.
- Bypass (BYPASS=1): if reg_write_w=1, rd_w!=0 and rd_w equals the rs index, rdN_d = result_w in the same cycle. With BYPASS=0, the new value appears only after the edge.
- load_use_hazard = valid_d AND mem_read_e AND rd_e!=0 AND ((rs1 used AND rd_e==rs1_d) OR (rs2 used AND rd_e==rs2_d)).
  - Purely combinational; the block does not self-stall.
  - The external unit drives stall_d and flush of ID/EX.
- Simultaneous flush_d and stall_d: flush wins.
- Reset asserted mid-stall: the register file clears and IF/ID becomes a NOP with valid=0.

Test Plan:
- Reset, then instr_f=0x00500093 (addi x1,x0,5), valid_f=1, pc_f=0x100 -> next cycle: valid_d=1, reg_write_d=1, rd_d=1, imm_d=5, pc_d=0x100, pc_plus4_d=0x104.
- reg_write_w=1, rd_w=3, result_w=0xDEADBEEF while decoding add x4,x3,x3 (0x00318233) -> rd1_d=rd2_d=0xDEADBEEF the same cycle with BYPASS=1. With BYPASS=0, the value appears only after the edge.
- Decode sw x2,-4(x1) (0xFE20AE23) -> mem_write_d=1, reg_write_d=0, imm_d=0xFFFFFFFC. Decode jal x1,-8 (0xFF9FF0EF) -> jump_d=1, imm_d=0xFFFFFFF8.
- mem_read_e=1, rd_e=5, decode add x6,x5,x0 -> load_use_hazard=1. With rd_e=0, or decoding lui x5,1 instead -> load_use_hazard=0.
- Load an instruction, then assert stall_d for 3 cycles with changing instr_f -> outputs held. Assert stall_d and flush_d together -> valid_d=0 and instr=NOP next cycle.
- REG_COUNT=16: decode addi x20,x0,1 -> illegal_d=1 with all enables 0. Opcode 0x7F -> illegal_d=1. Write x0 with 0x55 -> x0 still reads 0.
